pulse_train_gen: RTL
====================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of output channels.
REQ-002 SHALL have parameter CNT_W, default 8: width of per-channel pulse count.
REQ-003 SHALL have parameter HIGH_CYC, default 2: clock cycles each pulse is high, legal range 1..255.
REQ-004 SHALL have parameter LOW_CYC, default 2: clock cycles of low gap after each pulse, legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port load, input, 1 bit: writes count_in into the count register of channel ch_sel.
REQ-008 SHALL have port ch_sel, input, clog2(NUM_CH) bits: channel addressed by load.
REQ-009 SHALL have port count_in, input, CNT_W bits: pulse count to program.
REQ-010 SHALL have port start, input, 1 bit: begins one burst.
REQ-011 SHALL have port abort, input, 1 bit: terminates the burst in progress.
REQ-012 SHALL have port pulse_out, output, NUM_CH bits: registered pulse trains, one bit per channel.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle strobe at normal burst completion.

Function
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, DONE with a shared phase counter.
REQ-016 SHALL keep per-channel count registers, which retain their value across bursts, and per-channel remaining registers, which hold the working count.
REQ-017 SHALL, in IDLE, write count_in to count[ch_sel] on load.
REQ-018 SHALL ignore load while busy.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, on start in IDLE, copy all count registers into the remaining registers; for a simultaneous load, the copy SHALL use count_in for ch_sel.
REQ-021 SHALL, on start in IDLE, go to DONE if every remaining value is zero; otherwise it SHALL go to HIGH.
REQ-022 SHALL drive pulse_out[i] high during every HIGH cycle in which remaining[i] is nonzero, so the first pulse rises one cycle after start is sampled.
REQ-023 SHALL, after HIGH_CYC cycles in HIGH, decrement every nonzero remaining value and go to LOW.
REQ-024 SHALL hold all pulse_out bits low in LOW.
REQ-025 SHALL, after LOW_CYC cycles in LOW, go to DONE if all remaining values are zero; otherwise it SHALL go to HIGH.
REQ-026 SHALL assert done for exactly the one DONE cycle and then go to IDLE.
REQ-027 SHALL give a burst of N = max(count) pulses, with N nonzero, a length from the start-sample edge to the DONE-entry edge of N*(HIGH_CYC+LOW_CYC) cycles.
REQ-028 SHALL, on abort in HIGH or LOW, go to IDLE on the next edge with pulse_out cleared, remaining values cleared, and no done pulse; abort SHALL take priority over phase transitions.
REQ-029 SHALL treat count = 2^CNT_W-1 as legal, with no wrap; remaining values SHALL saturate at 0.

Reset
REQ-030 SHALL, while rst is high, asynchronously force state to IDLE, and phase counter, count registers, remaining registers, pulse_out and done to 0; busy SHALL therefore read 0.
REQ-031 SHALL, when rst asserts mid-burst, stop the burst immediately with no done pulse.

Structure
REQ-032 SHALL place the FSM state enum and the default parameter constants in package pulse_gen_pkg.
REQ-033 SHALL implement each channel's count register, remaining register and pulse_out bit in sub-module pulse_gen_channel, instantiated NUM_CH times.

Verification (defaults H=L=2, NUM_CH=4)
REQ-034 SHALL cover: load ch0=3, ch1=1, ch2=0, ch3=2, then start -> ch0 gives 3 pulses, ch1 gives 1, ch2 gives none, ch3 gives 2; each pulse is 2 cycles high and 2 low, the first rises 1 cycle after the start edge, and done fires 12 cycles after the start edge.
REQ-035 SHALL cover: all counts 0, start -> no pulses, done at the next cycle, busy high for 1 cycle.
REQ-036 SHALL cover: load ch0=5 while busy, plus a second start mid-burst -> both ignored, and the next burst uses the old value.
REQ-037 SHALL cover: abort in the second HIGH phase of a 3-pulse burst -> pulse_out low and IDLE next cycle, no done; a following start replays all 3 pulses.
REQ-038 SHALL cover: rst asserted mid-HIGH, asynchronously between clock edges -> outputs 0 immediately; after release, start with no load gives no pulses and an immediate done.
REQ-039 SHALL cover: load ch1=255 together with start in the same cycle -> 255 pulses on ch1, and done after 1020 cycles.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_pkg
//  Purpose  : Shared FSM state encoding and default parameter constants for
//             the multi-channel pulse train generator.
//  Revision : 1.0  initial release
// ============================================================================
package pulse_gen_pkg;

    localparam int c_DEF_NUM_CH   = 4;
    localparam int c_DEF_CNT_W    = 8;
    localparam int c_DEF_HIGH_CYC = 2;
    localparam int c_DEF_LOW_CYC  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_gen_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_channel
//  Purpose  : One output channel: persistent count register, working
//             remaining register and registered pulse output bit.
//  Ports    : clk, rst        - clock, async active-high reset
//             i_load/i_count  - write i_count into the count register
//             i_copy          - load remaining from the copy source
//             i_dec           - end of a high phase: decrement if nonzero
//             i_clear         - abort: clear remaining
//             i_pulse_en      - FSM will be in HIGH next cycle
//             o_src_nz        - copy source (count or bypassed i_count) != 0
//             o_rem_nz        - remaining != 0
//             o_pulse         - registered pulse output
//  Revision : 1.0  initial release
// ============================================================================
module pulse_gen_channel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_copy,
    input  logic             i_dec,
    input  logic             i_clear,
    input  logic             i_pulse_en,
    output logic             o_src_nz,
    output logic             o_rem_nz,
    output logic             o_pulse
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rem;
    logic             r_pulse;
    logic [CNT_W-1:0] w_src;

    // A load in the same cycle as start must be seen by the copy.
    assign w_src    = i_load ? i_count : r_count;
    assign o_src_nz = |w_src;
    assign o_rem_nz = |r_rem;
    assign o_pulse  = r_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_rem   <= '0;
            r_pulse <= 1'b0;
        end else begin
            if (i_load) begin
                r_count <= i_count;
            end
            if (i_clear) begin
                r_rem <= '0;
            end else if (i_copy) begin
                r_rem <= w_src;
            end else if (i_dec && (|r_rem)) begin
                r_rem <= r_rem - 1'b1;
            end
            // Output is timed to coincide with the HIGH state cycles, so it
            // looks at the value remaining will hold during that cycle.
            r_pulse <= i_pulse_en && (i_copy ? (|w_src) : (|r_rem));
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_train_gen
//  Purpose  : Burst generator driving NUM_CH pulse trains. Each channel emits
//             its programmed number of pulses (HIGH_CYC high, LOW_CYC low);
//             all channels share one phase counter and FSM.
//  Ports    : clk, rst       - clock, async active-high reset
//             load/ch_sel/count_in - program a channel count (IDLE only)
//             start          - begin a burst (IDLE only)
//             abort          - terminate a burst in HIGH or LOW
//             pulse_out      - registered pulse trains
//             busy           - FSM not in IDLE
//             done           - one-cycle strobe on normal completion
//  Revision : 1.0  initial release
// ============================================================================
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH   = c_DEF_NUM_CH,
    parameter int CNT_W    = c_DEF_CNT_W,
    parameter int HIGH_CYC = c_DEF_HIGH_CYC,
    parameter int LOW_CYC  = c_DEF_LOW_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [CNT_W-1:0]          count_in,
    input  logic                      start,
    input  logic                      abort,
    output logic [NUM_CH-1:0]         pulse_out,
    output logic                      busy,
    output logic                      done
);

    localparam int c_CH_W = $clog2(NUM_CH);

    state_t            r_state;
    logic [7:0]        r_phase;
    logic              r_done;

    logic [NUM_CH-1:0] w_src_nz;
    logic [NUM_CH-1:0] w_rem_nz;
    logic              w_idle;
    logic              w_in_high;
    logic              w_in_low;
    logic              w_start_go;
    logic              w_high_end;
    logic              w_low_end;
    logic              w_abort;
    logic              w_go_high;

    assign w_idle     = (r_state == S_IDLE);
    assign w_in_high  = (r_state == S_HIGH);
    assign w_in_low   = (r_state == S_LOW);
    assign w_start_go = w_idle && start;
    assign w_high_end = w_in_high && (r_phase == 8'(HIGH_CYC - 1));
    assign w_low_end  = w_in_low  && (r_phase == 8'(LOW_CYC - 1));
    assign w_abort    = abort && (w_in_high || w_in_low);

    // Next state will be HIGH: lets each channel register its pulse bit so
    // that it lines up with the HIGH state rather than lagging by a cycle.
    assign w_go_high = !w_abort &&
                       ((w_start_go && (|w_src_nz)) ||
                        (w_in_high && !w_high_end) ||
                        (w_low_end && (|w_rem_nz)));

    assign busy = !w_idle;
    assign done = r_done;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pulse_gen_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_idle && load && (ch_sel == c_CH_W'(gi))),
            .i_count    (count_in),
            .i_copy     (w_start_go),
            .i_dec      (w_high_end && !w_abort),
            .i_clear    (w_abort),
            .i_pulse_en (w_go_high),
            .o_src_nz   (w_src_nz[gi]),
            .o_rem_nz   (w_rem_nz[gi]),
            .o_pulse    (pulse_out[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase <= 8'd0;
                    if (start) begin
                        if (|w_src_nz) begin
                            r_state <= S_HIGH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_phase <= 8'd0;
                    end else if (w_high_end) begin
                        r_state <= S_LOW;
                        r_phase <= 8'd0;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_phase <= 8'd0;
                    end else if (w_low_end) begin
                        r_phase <= 8'd0;
                        if (|w_rem_nz) begin
                            r_state <= S_HIGH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_phase <= 8'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
